rule_hit_counter: RTL
=====================

Name: rule_hit_counter

Overview:
- Statistics stage directly downstream of the lookup block; consumes its countid_valid/countid stream (matched rule id, 0-63).
- Keeps one 32-bit hit counter per rule plus one 32-bit total-hit counter.
- Counters are readable and writable over the same localbus used by the search engines, so software can read rule statistics and clear or preset them.

Parameters:
- BLK_SEL, 3'd4, value of localbus_data[18:16] at ALE that selects this block.
- NUM_RULES, 64, number of rule counters; countid width is 6.
- CNT_W, 32, counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- countid_valid  in  1  one-cycle strobe: a rule matched
- countid  in  6  matched rule id
- localbus_cs_n  in  1  chip select, active low
- localbus_rd_wr  in  1  1 = read, 0 = write
- localbus_data  in  32  address phase (at ALE) or write data
- localbus_ale  in  1  address latch enable
- localbus_ack_n  out  1  access acknowledge, active low
- localbus_data_out  out  32  read data, valid while ack_n is low

Behaviour:
- Clock and reset: one clock (clk). Reset (named reset) is asynchronous and active-high.
- Reset values:
  - All counters = 0.
  - localbus_ack_n = 1, localbus_data_out = 0.
  - FSM = IDLE; pipeline valid bits = 0.
  - Reset mid-access aborts it; no ack is issued.
- Address map (latched index addr[6:0] = localbus_data[6:0]):
  - 0-63: rule counter[addr].
  - 64: total counter.
  - 65-127: unmapped; reads return 0, writes are ignored, both are acked.
- Update pipeline, fixed 2 cycles, accepts one hit per cycle with no backpressure:
  - S1, cycle after countid_valid: register id, read counter[id] and total.
  - S2: write counter[id]+1 and total+1.
  - Increments wrap modulo 2^32; 0xFFFFFFFF+1 = 0.
- Back-to-back hits, same id: S1 forwards the S2 write value, so N consecutive hits on one id add exactly N. Total forwards the same way.
- Host FSM states:
  - IDLE: ale=1 and localbus_data[18:16]==BLK_SEL -> latch addr, go to ADDR. ALE for any other select value is ignored.
  - ADDR: wait for cs_n=0. Sample rd_wr -> ACCESS.
  - ACCESS, one cycle:
    - Read: data_out = target value.
    - Write: target <= localbus_data.
    - Next state is ACK.
  - ACK: ack_n=0 and data_out held. Stay while cs_n=0. On cs_n=1: ack_n=1, data_out=0, go to IDLE.
  - A new ALE while in ADDR re-latches addr (last address wins).
- Collisions in ACCESS against S2:
  - Read of an index S2 writes in the same cycle returns the S2 (incremented) value.
  - Write to an index S2 writes in the same cycle: host value wins and that increment is lost. For index 64 the host value likewise wins over the total increment.
  - The forwarding path must see the host write, so a hit in S1 that cycle on the same index produces host value+1 in the next cycle.
- Ack latency: ack_n falls 2 cycles after the first cycle cs_n=0 is sampled in ADDR.

Test Plan:
- Reset, then read addr 5 -> ack_n low 2 cycles after cs_n, data_out = 0; ack_n=1 and data_out=0 one cycle after cs_n rises.
- Pulses countid=3 on cycles t, t+1, t+2, then countid=7 once -> read addr 3 = 3, addr 7 = 1, addr 64 = 4.
- Write 0xFFFFFFFE to addr 10, then 3 hits on id 10 -> read addr 10 = 0x00000001; total = 3.
- Hit on id 20 timed so S2 lands in the ACCESS cycle of a write of 0 to addr 20 -> read = 0. Repeat with a read -> returns 1.
- ALE with localbus_data[18:16]=3'd2 -> no ack_n activity. Read addr 100 -> ack with data 0. Write addr 100 -> acked, no counter changes.
- Assert reset during ACK with counters nonzero -> ack_n=1 immediately, all counters read 0 after release.

Source files
------------

// File: rtl/rule_hit_counter.sv
`default_nettype none
// ============================================================================
// Module   : rule_hit_counter
// Purpose  : Per-rule and total hit counters fed by the lookup countid stream,
//            readable and writable over the localbus.
// Revision : 1.0 - initial release
// ============================================================================
module rule_hit_counter #(
    parameter logic [2:0] BLK_SEL   = 3'd4,
    parameter int         NUM_RULES = 64,
    parameter int         CNT_W     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         countid_valid,
    input  logic [$clog2(NUM_RULES)-1:0] countid,
    input  logic                         localbus_cs_n,
    input  logic                         localbus_rd_wr,
    input  logic [31:0]                  localbus_data,
    input  logic                         localbus_ale,
    output logic                         localbus_ack_n,
    output logic [31:0]                  localbus_data_out
);

    localparam int         ID_W        = $clog2(NUM_RULES);
    localparam logic [6:0] c_total_idx = 7'(NUM_RULES);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_addr   = 2'd1;
    localparam logic [1:0] c_access = 2'd2;
    localparam logic [1:0] c_ack    = 2'd3;

    logic [1:0]       r_state;
    logic [6:0]       r_addr;
    logic             r_rd;
    logic             r_ack_n;
    logic [31:0]      r_data_out;

    logic             r_s1_valid;
    logic [ID_W-1:0]  r_s1_id;
    logic             r_s2_valid;
    logic [ID_W-1:0]  r_s2_id;
    logic [CNT_W-1:0] r_s2_cnt;
    logic [CNT_W-1:0] r_s2_tot;

    logic [CNT_W-1:0] r_cnt [NUM_RULES];
    logic [CNT_W-1:0] r_total;

    logic             w_host_wr;
    logic             w_addr_is_rule;
    logic             w_addr_is_tot;
    logic [ID_W-1:0]  w_addr_id;
    logic             w_sel;
    logic [CNT_W-1:0] w_s1_cnt;
    logic [CNT_W-1:0] w_s1_tot;
    logic [31:0]      w_rd_val;

    assign localbus_ack_n    = r_ack_n;
    assign localbus_data_out = r_data_out;

    always_comb begin
        w_host_wr      = (r_state == c_access) && !r_rd;
        w_addr_is_rule = r_addr < c_total_idx;
        w_addr_is_tot  = r_addr == c_total_idx;
        w_addr_id      = r_addr[ID_W-1:0];
        w_sel          = localbus_ale && (localbus_data[18:16] == BLK_SEL);

        // S1 operand: a same-cycle host write beats the in-flight S2 value,
        // which beats the stored counter.
        if (w_host_wr && w_addr_is_rule && (w_addr_id == r_s1_id)) begin
            w_s1_cnt = localbus_data;
        end else if (r_s2_valid && (r_s2_id == r_s1_id)) begin
            w_s1_cnt = r_s2_cnt;
        end else begin
            w_s1_cnt = r_cnt[r_s1_id];
        end

        if (w_host_wr && w_addr_is_tot) begin
            w_s1_tot = localbus_data;
        end else if (r_s2_valid) begin
            w_s1_tot = r_s2_tot;
        end else begin
            w_s1_tot = r_total;
        end

        w_rd_val = '0;
        if (w_addr_is_rule) begin
            w_rd_val = (r_s2_valid && (r_s2_id == w_addr_id)) ? r_s2_cnt : r_cnt[w_addr_id];
        end else if (w_addr_is_tot) begin
            w_rd_val = r_s2_valid ? r_s2_tot : r_total;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_cnt   <= '0;
            r_s2_tot   <= '0;
        end else begin
            r_s1_valid <= countid_valid;
            if (countid_valid) begin
                r_s1_id <= countid;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_id  <= r_s1_id;
                r_s2_cnt <= w_s1_cnt + CNT_W'(1);
                r_s2_tot <= w_s1_tot + CNT_W'(1);
            end
        end
    end

    // Host write takes priority; a colliding S2 increment is dropped.
    generate
        for (genvar gi = 0; gi < NUM_RULES; gi++) begin : g_cnt
            localparam logic [ID_W-1:0] c_idx = ID_W'(gi);
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt[gi] <= '0;
                end else if (w_host_wr && w_addr_is_rule && (w_addr_id == c_idx)) begin
                    r_cnt[gi] <= localbus_data;
                end else if (r_s2_valid && (r_s2_id == c_idx)) begin
                    r_cnt[gi] <= r_s2_cnt;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_total <= '0;
        end else if (w_host_wr && w_addr_is_tot) begin
            r_total <= localbus_data;
        end else if (r_s2_valid) begin
            r_total <= r_s2_tot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_idle;
            r_addr     <= '0;
            r_rd       <= 1'b0;
            r_ack_n    <= 1'b1;
            r_data_out <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_sel) begin
                        r_addr  <= localbus_data[6:0];
                        r_state <= c_addr;
                    end
                end
                c_addr: begin
                    if (w_sel) begin
                        r_addr <= localbus_data[6:0];
                    end else if (!localbus_cs_n) begin
                        r_rd    <= localbus_rd_wr;
                        r_state <= c_access;
                    end
                end
                c_access: begin
                    r_ack_n    <= 1'b0;
                    r_data_out <= r_rd ? w_rd_val : 32'd0;
                    r_state    <= c_ack;
                end
                c_ack: begin
                    if (localbus_cs_n) begin
                        r_ack_n    <= 1'b1;
                        r_data_out <= '0;
                        r_state    <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
